// File: rtl/line_mem_pkg.sv
// Shared types and default sizes for the 128-bit line memory responder.
package line_mem_pkg;

   localparam int DEF_ADDR_W  = 28;
   localparam int DEF_DATA_W  = 128;
   localparam int DEF_IDX_W   = 10;
   localparam int DEF_LATENCY = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Counter preload: the accepting edge already accounts for one cycle.
   function automatic logic [7:0] lat_load(input int lat);
      return 8'(lat - 1);
   endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Cache-to-memory line request bus: level requests from the cache, one-cycle ready from memory.
interface line_mem_responder_if #(
   parameter int ADDR_W = line_mem_pkg::DEF_ADDR_W,
   parameter int DATA_W = line_mem_pkg::DEF_DATA_W
);
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/line_mem_store.sv
// Line storage array with per-line valid bits; only the valid bits are reset,
// so unwritten lines read back as zero.
module line_mem_store
   import line_mem_pkg::*;
#(
   parameter int IDX_W  = DEF_IDX_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]  valid_r;

   // Data array write port
   always_ff @(posedge clk) begin
      if (we && !RST) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Valid bits mark lines written since the last reset
   always_ff @(posedge clk) begin
      if (RST) begin
         valid_r <= '0;
      end else if (we) begin
         valid_r[waddr] <= 1'b1;
      end
   end

   assign rdata = valid_r[raddr] ? mem_r[raddr] : {DATA_W{1'b0}};

endmodule

// File: rtl/line_mem_responder.sv
// Slow line memory: accepts one read or write, answers after LATENCY cycles
// with a single-cycle mem_ready pulse, and keeps completion statistics.
module line_mem_responder
   import line_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic                 clk,
   input  logic                 RST,
   line_mem_responder_if.slave  bus,
   output logic [31:0]          rd_count,
   output logic [31:0]          wr_count,
   output logic                 proto_err
);

   localparam bit LAT_ONE = (LATENCY == 32'sd1);

   state_t            state_r;
   op_t               op_r;
   logic [IDX_W-1:0]  addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [7:0]        cnt_r;
   logic              ready_r;
   logic [DATA_W-1:0] rdata_r;
   logic [31:0]       rd_count_r;
   logic [31:0]       wr_count_r;
   logic              proto_r;

   logic              req_s;
   op_t               in_op_s;
   logic              commit_s;
   op_t               commit_op_s;
   logic [IDX_W-1:0]  commit_addr_s;
   logic [DATA_W-1:0] commit_wdata_s;
   logic              we_s;
   logic [DATA_W-1:0] store_rdata_s;
   logic              unused_addr_s;

   assign req_s         = bus.mem_read | bus.mem_write;
   assign in_op_s       = bus.mem_write ? OP_WR : OP_RD;
   assign unused_addr_s = ^bus.mem_addr[ADDR_W-1:IDX_W];

   // Select the transaction that completes at the coming edge; with unit latency
   // it comes straight from the bus rather than the capture registers.
   always_comb begin
      commit_s       = 1'b0;
      commit_op_s    = op_r;
      commit_addr_s  = addr_r;
      commit_wdata_s = wdata_r;
      case (state_r)
         IDLE: begin
            if (LAT_ONE && req_s) begin
               commit_s       = 1'b1;
               commit_op_s    = in_op_s;
               commit_addr_s  = bus.mem_addr[IDX_W-1:0];
               commit_wdata_s = bus.mem_wdata;
            end else begin
               commit_s = 1'b0;
            end
         end
         BUSY: begin
            if (cnt_r <= 8'd1) begin
               commit_s = 1'b1;
            end else begin
               commit_s = 1'b0;
            end
         end
         default: commit_s = 1'b0;
      endcase
   end

   assign we_s = commit_s & (commit_op_s == OP_WR) & ~RST;

   line_mem_store #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
   ) u_store (
      .clk   (clk),
      .RST   (RST),
      .we    (we_s),
      .waddr (commit_addr_s),
      .wdata (commit_wdata_s),
      .raddr (commit_addr_s),
      .rdata (store_rdata_s)
   );

   // Request FSM, latency counter, response registers and statistics
   always_ff @(posedge clk) begin
      if (RST) begin
         state_r    <= IDLE;
         op_r       <= OP_RD;
         addr_r     <= '0;
         wdata_r    <= '0;
         cnt_r      <= 8'd0;
         ready_r    <= 1'b0;
         rdata_r    <= '0;
         rd_count_r <= 32'd0;
         wr_count_r <= 32'd0;
         proto_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_r <= 1'b0;
               if (req_s) begin
                  op_r    <= in_op_s;
                  addr_r  <= bus.mem_addr[IDX_W-1:0];
                  wdata_r <= bus.mem_wdata;
                  cnt_r   <= lat_load(LATENCY);
                  if (bus.mem_read && bus.mem_write) begin
                     proto_r <= 1'b1;
                  end
                  if (commit_s) begin
                     state_r <= RESP;
                     ready_r <= 1'b1;
                     if (commit_op_s == OP_RD) begin
                        rdata_r <= store_rdata_s;
                     end
                  end else begin
                     state_r <= BUSY;
                  end
               end
            end
            BUSY: begin
               cnt_r <= cnt_r - 8'd1;
               if (commit_s) begin
                  state_r <= RESP;
                  ready_r <= 1'b1;
                  if (commit_op_s == OP_RD) begin
                     rdata_r <= store_rdata_s;
                  end
               end
            end
            RESP: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               if (op_r == OP_WR) begin
                  wr_count_r <= wr_count_r + 32'd1;
               end else begin
                  rd_count_r <= rd_count_r + 32'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_ready = ready_r;
   assign bus.mem_rdata = rdata_r;
   assign rd_count      = rd_count_r;
   assign wr_count      = wr_count_r;
   assign proto_err     = proto_r;

endmodule
